// File: rtl/tq_pkg.sv
// tq_pkg: constants shared by the transform/quantise blocks.
//   TQ_IW         width of one transform-stage output element (signed)
//   TQ_RW         working width for rounding/saturation (one guard bit over TQ_IW
//                 so that adding the rounding bias can never overflow)
//   tq_rnd_bias() rounding bias 2^(s-1) for a right shift of s (0 when s == 0)
package tq_pkg;

    localparam int TQ_IW = 28;
    localparam int TQ_RW = TQ_IW + 1;

    function automatic logic signed [TQ_RW-1:0] tq_rnd_bias(input int s);
        if (s <= 0) return '0;
        return TQ_RW'(1) << (s - 1);
    endfunction

endpackage

// File: rtl/tq_transpose_4x4_round_sat.sv
// tq_round_sat: combinational round-half-up right shift plus saturation of one
// element. Both shift amounts are fixed, so both results are built and the mode
// selects between them (no barrel shifter).
//   i_x       signed TQ_IW-bit input element
//   i_inverse 1 = shift by SHIFT_INV, 0 = shift by SHIFT_FWD
//   o_y       signed OW-bit rounded, saturated result
module tq_round_sat
    import tq_pkg::*;
#(
    parameter int SHIFT_FWD = 1,
    parameter int SHIFT_INV = 7,
    parameter int OW        = 16
) (
    input  logic signed [TQ_IW-1:0] i_x,
    input  logic                    i_inverse,
    output logic signed [OW-1:0]    o_y
);

    localparam logic signed [TQ_RW-1:0] BIAS_F  = tq_rnd_bias(SHIFT_FWD);
    localparam logic signed [TQ_RW-1:0] BIAS_I  = tq_rnd_bias(SHIFT_INV);
    localparam logic signed [TQ_RW-1:0] SAT_MAX = TQ_RW'((64'sd1 <<< (OW - 1)) - 64'sd1);
    localparam logic signed [TQ_RW-1:0] SAT_MIN = TQ_RW'(-(64'sd1 <<< (OW - 1)));

    logic signed [TQ_RW-1:0] w_ext;
    logic signed [TQ_RW-1:0] w_fwd;
    logic signed [TQ_RW-1:0] w_inv;
    logic signed [TQ_RW-1:0] w_r;

    assign w_ext = {i_x[TQ_IW-1], i_x};
    assign w_fwd = (w_ext + BIAS_F) >>> SHIFT_FWD;
    assign w_inv = (w_ext + BIAS_I) >>> SHIFT_INV;
    assign w_r   = i_inverse ? w_inv : w_fwd;

    always_comb begin
        o_y = w_r[OW-1:0];
        if (w_r > SAT_MAX)      o_y = SAT_MAX[OW-1:0];
        else if (w_r < SAT_MIN) o_y = SAT_MIN[OW-1:0];
    end

endmodule

// File: rtl/tq_transpose_4x4.sv
// tq_transpose_4x4: rounds/saturates incoming transform rows and transposes each
// 4x4 block through a ping-pong pair of banks, emitting one column per transfer.
//   clk, rst            clock, asynchronous active-low reset
//   inverse             mode of the presented row (sampled on row 0 only)
//   i_valid/i_ready     row handshake; i_0..i_3 signed TQ_IW-bit row elements
//   o_valid/o_ready     column handshake; o_0..o_3 signed OW-bit column (o_k = row k)
//   o_inverse           mode latched for the block being read
//   o_last              marks the 4th column of a block
module tq_transpose_4x4
    import tq_pkg::*;
#(
    parameter int SHIFT_FWD = 1,
    parameter int SHIFT_INV = 7,
    parameter int OW        = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inverse,
    input  logic                    i_valid,
    output logic                    i_ready,
    input  logic signed [TQ_IW-1:0] i_0,
    input  logic signed [TQ_IW-1:0] i_1,
    input  logic signed [TQ_IW-1:0] i_2,
    input  logic signed [TQ_IW-1:0] i_3,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic signed [OW-1:0]    o_0,
    output logic signed [OW-1:0]    o_1,
    output logic signed [OW-1:0]    o_2,
    output logic signed [OW-1:0]    o_3,
    output logic                    o_inverse,
    output logic                    o_last
);

    // r_mem[bank][row][element]; data is not reset, only the flags qualify it
    logic signed [OW-1:0] r_mem [2][4][4];
    logic [1:0]           r_full;
    logic [1:0]           r_mode;
    logic                 r_wbank;
    logic                 r_rbank;
    logic [1:0]           r_wrow;
    logic [1:0]           r_col;

    logic signed [TQ_IW-1:0] w_in [4];
    logic signed [OW-1:0]    w_rs [4];
    logic                    w_mode;
    logic                    w_wr;
    logic                    w_rd;

    assign w_in[0] = i_0;
    assign w_in[1] = i_1;
    assign w_in[2] = i_2;
    assign w_in[3] = i_3;

    // Row 0 takes its mode straight from the input; later rows reuse the latched one.
    assign w_mode  = (r_wrow == 2'd0) ? inverse : r_mode[r_wbank];

    assign i_ready   = ~r_full[r_wbank];
    assign o_valid   = r_full[r_rbank];
    assign w_wr      = i_valid & i_ready;
    assign w_rd      = o_valid & o_ready;
    assign o_last    = o_valid & (r_col == 2'd3);
    assign o_inverse = r_mode[r_rbank];

    assign o_0 = r_mem[r_rbank][0][r_col];
    assign o_1 = r_mem[r_rbank][1][r_col];
    assign o_2 = r_mem[r_rbank][2][r_col];
    assign o_3 = r_mem[r_rbank][3][r_col];

    for (genvar g = 0; g < 4; g++) begin : g_rs
        tq_round_sat #(
            .SHIFT_FWD (SHIFT_FWD),
            .SHIFT_INV (SHIFT_INV),
            .OW        (OW)
        ) u_rs (
            .i_x       (w_in[g]),
            .i_inverse (w_mode),
            .o_y       (w_rs[g])
        );
    end

    // Write and read always target different banks (write needs !full, read
    // needs full), so a simultaneous fill and drain update distinct flag bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full  <= '0;
            r_mode  <= '0;
            r_wbank <= 1'b0;
            r_rbank <= 1'b0;
            r_wrow  <= '0;
            r_col   <= '0;
        end else begin
            if (w_wr) begin
                if (r_wrow == 2'd0) r_mode[r_wbank] <= inverse;
                r_wrow <= r_wrow + 2'd1;
                if (r_wrow == 2'd3) begin
                    r_full[r_wbank] <= 1'b1;
                    r_wbank         <= ~r_wbank;
                end
            end
            if (w_rd) begin
                r_col <= r_col + 2'd1;
                if (r_col == 2'd3) begin
                    r_full[r_rbank] <= 1'b0;
                    r_rbank         <= ~r_rbank;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int k = 0; k < 4; k++) r_mem[r_wbank][r_wrow][k] <= w_rs[k];
        end
    end

endmodule

// File: tb/tb_tq_transpose_4x4.sv
// tb_tq_transpose_4x4: randomized and directed checks of tq_transpose_4x4 against
// a queue-based reference model of complete blocks awaiting read-out.
module tb_tq_transpose_4x4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic inverse = 1'b0;
    logic i_valid = 1'b0;
    logic o_ready = 1'b0;
    logic signed [27:0] i_0 = '0, i_1 = '0, i_2 = '0, i_3 = '0;
    logic i_ready, o_valid, o_inverse, o_last;
    logic signed [15:0] o_0, o_1, o_2, o_3;

    tq_transpose_4x4 #(.SHIFT_FWD(1), .SHIFT_INV(7), .OW(16)) dut (
        .clk(clk), .rst(rst), .inverse(inverse), .i_valid(i_valid), .i_ready(i_ready),
        .i_0(i_0), .i_1(i_1), .i_2(i_2), .i_3(i_3),
        .o_valid(o_valid), .o_ready(o_ready),
        .o_0(o_0), .o_1(o_1), .o_2(o_2), .o_3(o_3),
        .o_inverse(o_inverse), .o_last(o_last)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: qd holds 16 values per complete block (row-major), qm its mode
    int     qd[$];
    bit     qm[$];
    int     part[16];
    bit     pmode;
    int     prow;
    int     pcol;

    longint rw[4];
    bit     cur_iv, cur_inv, cur_ordy;
    bit     e_irdy, e_ovld, e_last, e_inv;
    int     e_o[4];

    function automatic int rs(input longint x, input bit inv);
        longint s;
        longint r;
        s = inv ? 64'sd7 : 64'sd1;
        r = (x + (longint'(1) <<< (s - 1))) >>> s;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    function automatic longint rnd_elem();
        logic signed [27:0] t;
        t = 28'($urandom);
        case ($urandom % 4)
            0: return longint'(t);
            1: return longint'($urandom_range(0, 60000)) - 30000;
            2: return ($urandom % 2) ? 64'sd134217727 : -64'sd134217728;
            default: return longint'($urandom_range(0, 600)) - 300;
        endcase
    endfunction

    function automatic logic [67:0] pack_obs();
        return {i_ready, o_valid, o_last, e_ovld ? {o_inverse, o_0, o_1, o_2, o_3} : 65'd0};
    endfunction

    function automatic logic [67:0] pack_exp();
        return {e_irdy, e_ovld, e_last,
                e_ovld ? {e_inv, 16'(e_o[0]), 16'(e_o[1]), 16'(e_o[2]), 16'(e_o[3])} : 65'd0};
    endfunction

    task automatic model_reset();
        qd.delete();
        qm.delete();
        prow  = 0;
        pcol  = 0;
        pmode = 0;
    endtask

    task automatic new_row();
        for (int k = 0; k < 4; k++) rw[k] = rnd_elem();
    endtask

    // drive one cycle's inputs, then at the falling edge compute model expectations
    task automatic step(input bit iv, input bit inv, input bit ordy);
        cur_iv = iv; cur_inv = inv; cur_ordy = ordy;
        i_valid = iv; inverse = inv; o_ready = ordy;
        i_0 = rw[0][27:0]; i_1 = rw[1][27:0]; i_2 = rw[2][27:0]; i_3 = rw[3][27:0];
        @(negedge clk);
        e_irdy = (qm.size() < 2);
        e_ovld = (qm.size() > 0);
        e_last = e_ovld && (pcol == 3);
        e_inv  = e_ovld ? qm[0] : 1'b0;
        for (int k = 0; k < 4; k++) e_o[k] = e_ovld ? qd[k*4 + pcol] : 0;
    endtask

    // apply the handshakes the model expects, then move past the next rising edge
    task automatic adv();
        bit wr;
        bit rd;
        wr = cur_iv && e_irdy;
        rd = cur_ordy && e_ovld;
        if (rd) begin
            pcol++;
            if (pcol == 4) begin
                pcol = 0;
                repeat (16) void'(qd.pop_front());
                void'(qm.pop_front());
            end
        end
        if (wr) begin
            if (prow == 0) pmode = cur_inv;
            for (int k = 0; k < 4; k++) part[prow*4 + k] = rs(rw[k], pmode);
            prow++;
            if (prow == 4) begin
                prow = 0;
                for (int i = 0; i < 16; i++) qd.push_back(part[i]);
                qm.push_back(pmode);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        n_tests++;
        if ({i_ready, o_valid, o_last, o_inverse} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_state got %b exp 1000", {i_ready, o_valid, o_last, o_inverse});
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fwd_example();
        logic signed [15:0] ec[4];
        ec[0] = 16'sd3; ec[1] = -16'sd2; ec[2] = 16'sd1; ec[3] = -16'sd1;
        for (int c = 0; c < 8; c++) begin
            if (c == 0) begin rw[0] = 5; rw[1] = -5; rw[2] = 2; rw[3] = -3; end
            else begin rw[0] = 0; rw[1] = 0; rw[2] = 0; rw[3] = 0; end
            step(c < 4, 1'b0, 1'b1);
            n_tests++;
            if (pack_obs() !== pack_exp()) begin
                n_fail++;
                $display("FAIL fwd_example t=%0t got %h exp %h", $time, pack_obs(), pack_exp());
            end
            if (c >= 4) begin
                n_tests++;
                if (o_valid !== 1'b1 || o_0 !== ec[c-4] || {o_1, o_2, o_3} !== 48'd0 ||
                    o_last !== (c == 7) || o_inverse !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fwd_example_col%0d got v=%b o0=%0d last=%b exp o0=%0d",
                             c - 4, o_valid, o_0, o_last, ec[c-4]);
                end
            end
            adv();
        end
    endtask

    task automatic test_inv_sat();
        logic signed [15:0] ec[4];
        for (int b = 0; b < 2; b++) begin
            if (b == 0) begin ec[0] = 16'sd64;   ec[1] = -16'sd64;   end
            else        begin ec[0] = 16'sd4096; ec[1] = -16'sd4096; end
            ec[2] = 16'sd32767; ec[3] = -16'sd32768;
            for (int c = 0; c < 8; c++) begin
                if (c == 0) begin rw[0] = 8191; rw[1] = -8192; rw[2] = 64'sd1 <<< 26; rw[3] = -(64'sd1 <<< 26); end
                else new_row();
                // rows 1-3 offer the opposite mode, which must be ignored
                step(c < 4, (c == 0) ? (b == 0) : (b != 0), 1'b1);
                n_tests++;
                if (pack_obs() !== pack_exp()) begin
                    n_fail++;
                    $display("FAIL inv_sat t=%0t got %h exp %h", $time, pack_obs(), pack_exp());
                end
                if (c >= 4) begin
                    n_tests++;
                    if (o_valid !== 1'b1 || o_0 !== ec[c-4] || o_inverse !== (b == 0)) begin
                        n_fail++;
                        $display("FAIL inv_sat_b%0d_col%0d got o0=%0d inv=%b exp o0=%0d inv=%b",
                                 b, c - 4, o_0, o_inverse, ec[c-4], (b == 0));
                    end
                end
                adv();
            end
        end
    endtask

    task automatic test_backpressure();
        int nv;
        for (int c = 0; c < 12; c++) begin
            new_row();
            step(1'b1, 1'($urandom % 2), 1'b0);
            n_tests++;
            if (pack_obs() !== pack_exp() || i_ready !== (c < 8)) begin
                n_fail++;
                $display("FAIL backpressure_fill row%0d got %h exp %h rdy=%b", c + 1,
                         pack_obs(), pack_exp(), i_ready);
            end
            adv();
        end
        nv = 0;
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b0, 1'b1);
            if (o_valid === 1'b1) nv++;
            n_tests++;
            if (pack_obs() !== pack_exp()) begin
                n_fail++;
                $display("FAIL backpressure_drain t=%0t got %h exp %h", $time, pack_obs(), pack_exp());
            end
            adv();
        end
        n_tests++;
        if (nv != 8) begin
            n_fail++;
            $display("FAIL backpressure_columns got %0d exp 8", nv);
        end
    endtask

    task automatic test_back_to_back();
        int nv;
        nv = 0;
        for (int c = 0; c < 20; c++) begin
            new_row();
            step(c < 16, 1'($urandom % 2), 1'b1);
            if (c >= 4 && c < 16 && o_valid === 1'b1 && i_ready === 1'b1) nv++;
            n_tests++;
            if (pack_obs() !== pack_exp()) begin
                n_fail++;
                $display("FAIL back_to_back cyc%0d got %h exp %h", c, pack_obs(), pack_exp());
            end
            adv();
        end
        n_tests++;
        if (nv != 12) begin
            n_fail++;
            $display("FAIL back_to_back_no_bubble got %0d exp 12", nv);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            new_row();
            step(($urandom % 4) != 0 && c < 388, 1'($urandom % 2), ($urandom % 3) != 0 || c >= 388);
            n_tests++;
            if (pack_obs() !== pack_exp()) begin
                n_fail++;
                $display("FAIL random cyc%0d got %h exp %h", c, pack_obs(), pack_exp());
            end
            adv();
        end
    endtask

    task automatic test_mid_reset();
        for (int c = 0; c < 6; c++) begin
            new_row();
            step(1'b1, 1'b1, 1'b0);
            n_tests++;
            if (pack_obs() !== pack_exp()) begin
                n_fail++;
                $display("FAIL mid_reset_fill got %h exp %h", pack_obs(), pack_exp());
            end
            adv();
        end
        i_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_tests++;
        if ({i_ready, o_valid, o_last, o_inverse} !== 4'b1000) begin
            n_fail++;
            $display("FAIL mid_reset_immediate got %b exp 1000", {i_ready, o_valid, o_last, o_inverse});
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 9; c++) begin
            new_row();
            step(c < 4, 1'b0, 1'b1);
            n_tests++;
            if (pack_obs() !== pack_exp() || (c >= 4 && c < 8 && o_valid !== 1'b1)) begin
                n_fail++;
                $display("FAIL mid_reset_block cyc%0d got %h exp %h", c, pack_obs(), pack_exp());
            end
            adv();
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) rw[k] = 0;
        test_reset();
        test_fwd_example();
        test_inv_sat();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tq_transpose_4x4.md
TQ_TRANSPOSE_4X4 -- requirements
Module: tq_transpose_4x4

Interface
REQ-001 Parameter SHIFT_FWD, default 1: right-shift applied to forward-mode results.
REQ-002 Parameter SHIFT_INV, default 7: right-shift applied to inverse-mode results.
REQ-003 Parameter OW, default 16: output coefficient width.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 inverse  input  1  mode of the row presented; 1 = inverse, 0 = forward.
REQ-007 i_valid  input  1  row i_0..i_3 valid this cycle.
REQ-008 i_ready  output  1  block can accept a row this cycle.
REQ-009 i_0..i_3  input  28 each, signed  one transform-stage output row.
REQ-010 o_valid  output  1  column o_0..o_3 valid.
REQ-011 o_ready  input  1  downstream accepts the column this cycle.
REQ-012 o_0..o_3  output  OW each, signed  one transposed column, element k = row k.
REQ-013 o_inverse  output  1  mode tag of the block being output.
REQ-014 o_last  output  1  asserted with the 4th column of a block.

Function
REQ-015 Row accept SHALL occur when i_valid and i_ready are both 1; column transfer SHALL occur when o_valid and o_ready are both 1.
REQ-016 Each accepted element SHALL be rounded as (x + 2^(s-1)) >>> s, with s = SHIFT_INV if the block's mode is 1, else SHIFT_FWD; the arithmetic SHALL use at least 29 bits with no overflow.
REQ-017 The rounded value SHALL saturate to [-2^(OW-1), 2^(OW-1)-1] before storage.
REQ-018 Storage SHALL be two 4x4 banks of OW-bit entries (ping-pong), each with a full flag.
REQ-019 A 2-bit write row counter SHALL store accepted row r into entries [r][0..3] of the write bank.
REQ-020 The block's mode SHALL be latched with row 0 and applied to rows 1-3; inverse SHALL be ignored on rows 1-3.
REQ-021 Accepting row 3 SHALL set the write bank's full flag, toggle the write bank, and wrap the row counter to 0.
REQ-022 i_ready SHALL equal NOT full[write bank].
REQ-023 o_valid SHALL equal full[read bank]; o_k SHALL equal entry [k][c] of the read bank, c = 2-bit column counter.
REQ-024 Each column transfer SHALL increment c; the transfer at c=3 SHALL clear full[read bank], toggle the read bank, and wrap c to 0.
REQ-025 o_last SHALL equal o_valid AND (c==3); o_inverse SHALL be the mode latched for the read bank.
REQ-026 Latency: column 0 of a block SHALL present o_valid in the cycle after its row 3 is accepted, provided the read bank is that bank.
REQ-027 With o_ready held 1 and rows arriving every cycle, throughput SHALL be one row in and one column out per cycle with no bubbles.
REQ-028 When a column-3 read clears a bank in the same cycle row 3 fills the other bank, both flag updates SHALL take effect.
REQ-029 With both banks full, i_ready SHALL be 0, and a row offered while i_ready is 0 SHALL be ignored.
REQ-030 When o_ready is 0, the o_* outputs SHALL hold stable.

Reset
REQ-031 rst low SHALL immediately clear both full flags, the row and column counters, the bank pointers, and latched modes; o_valid=0, o_last=0, o_inverse=0, i_ready=1.
REQ-032 Reset mid-block SHALL discard partial and full banks; bank data contents need not be cleared.

Structure
REQ-033 Shared tq package SHALL hold the 28-bit input width and the round/saturate width constants; SHIFT_* remain module parameters.
REQ-034 One sub-module tq_round_sat (combinational round plus saturate, one element) SHALL be instantiated four times.

Verification
REQ-035 Forward mode, row 0 = {5,-5,2,-3}, rows 1-3 = 0 -> column 0 = {3,0,0,0}, column 1 = {-2,0,0,0}, column 2 = {1,0,0,0}, column 3 = {-1,0,0,0}; o_last on column 3.
REQ-036 Inverse mode, element 8191 -> stored 64; element -8192 -> -64; o_inverse=1 throughout the block.
REQ-037 Forward mode, element 2^26 -> 32767; element -2^26 -> -32768.
REQ-038 Hold o_ready=0, stream 12 rows -> i_ready drops after row 8, rows 9-12 stall; with o_ready then set to 1 -> 8 columns in order, bank A then bank B.
REQ-039 Continuous rows with o_ready=1 -> o_valid continuous from cycle 5; the simultaneous fill/drain case of REQ-028 is exercised with no lost block.
REQ-040 rst pulse after 2 rows accepted -> o_valid=0 and i_ready=1 at once; the next 4 rows form a clean block.
